// File: rtl/imem_ctrl.sv
// imem_ctrl: synchronous-read instruction array with a stall-holding fetch port and a
// lock/drain-gated byte-enable programming port. Optional per-byte parity: IMEM_PARITY_EN.
module imem_ctrl #(
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [31:0]       fetch_data,
  output logic              fetch_valid,
  output logic              fetch_misalign,
  input  logic              prog_lock,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  input  logic [3:0]        prog_be,
  output logic              prog_busy,
  output logic [15:0]       prog_count,
  output logic              parity_err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  // state | meaning
  // RUN   | fetch port active, programming port ignored
  // PROG  | bootloader owns the array, writes accepted and counted
  // DRAIN | one-cycle gap after unlock before fetch resumes
  typedef enum logic [1:0] {RUN, PROG, DRAIN} state_t;

  state_t state, state_nxt;

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] prog_idx;
  logic             fetch_block;
  logic             fetch_upd;
  logic             prog_wr;
  logic             enter_prog;
  logic             rd_perr;
  logic             parity_q;
  logic             unused_prog_lsb;

  assign fetch_idx       = fetch_addr[ADDR_W-1:2];
  assign prog_idx        = prog_addr[ADDR_W-1:2];
  assign unused_prog_lsb = ^prog_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fetch_block = 1'b0;
    fetch_upd   = 1'b0;
    prog_wr     = 1'b0;
    enter_prog  = 1'b0;
    case (state)
      RUN:     if (prog_lock) state_nxt = PROG;
      PROG:    if (!prog_lock) state_nxt = DRAIN;
      DRAIN:   state_nxt = prog_lock ? PROG : RUN;
      default: state_nxt = RUN;
    endcase
    // Fetch outputs are forced to NOP on the edge that leaves RUN, so PROG/DRAIN show NOP.
    fetch_block = (state_nxt != RUN);
    fetch_upd   = (state == RUN) && !stall;
    prog_wr     = (state == PROG) && prog_we && !rst;
    enter_prog  = (state != PROG) && (state_nxt == PROG);
  end

`ifdef IMEM_PARITY_EN
  logic [3:0] mem_par [DEPTH];

  always_ff @(posedge clk) begin
    if (prog_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (prog_be[i]) begin
          mem[prog_idx][8*i +: 8] <= prog_data[8*i +: 8];
          mem_par[prog_idx][i]    <= ^prog_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_perr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((^mem[fetch_idx][8*i +: 8]) != mem_par[fetch_idx][i]) rd_perr = 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (prog_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (prog_be[i]) mem[prog_idx][8*i +: 8] <= prog_data[8*i +: 8];
      end
    end
  end

  assign rd_perr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_data     <= NOP_WORD;
      fetch_valid    <= 1'b0;
      fetch_misalign <= 1'b0;
      parity_q       <= 1'b0;
    end else if (fetch_block) begin
      fetch_data     <= NOP_WORD;
      fetch_valid    <= 1'b0;
      fetch_misalign <= 1'b0;
      parity_q       <= 1'b0;
    end else if (fetch_upd) begin
      if (fetch_req) begin
        fetch_data     <= mem[fetch_idx];
        fetch_valid    <= 1'b1;
        fetch_misalign <= |fetch_addr[1:0];
        parity_q       <= rd_perr;
      end else begin
        fetch_valid <= 1'b0;
      end
    end
  end

  assign parity_err = parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_busy  <= 1'b0;
      prog_count <= 16'h0000;
    end else begin
      prog_busy <= (state_nxt != RUN);
      if (enter_prog)
        prog_count <= 16'h0000;
      else if (prog_wr && prog_count != 16'hFFFF)
        prog_count <= prog_count + 16'h0001;
    end
  end

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Parametrised instruction-memory controller for the RV32 core, between the fetch stage and the bootloader. It owns a synchronous-read word array with a registered fetch port that holds its output under pipeline stall, so fetch never rewinds its address. It also has a byte-enabled programming port gated by a lock/drain state machine, plus optional per-byte parity.

## Interface
Parameters:
- ADDR_W, 14, byte-address width of both ports; array depth is 2^(ADDR_W-2) words.
- NOP_WORD, 32'h0000_0013, word presented on fetch_data while fetch is blocked and after reset.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous active-high reset.
- fetch_req  in  1  fetch request for fetch_addr.
- fetch_addr  in  ADDR_W  byte address; word index = fetch_addr[ADDR_W-1:2].
- stall  in  1  pipeline stall; freezes fetch outputs.
- fetch_data  out  32  registered instruction word.
- fetch_valid  out  1  fetch_data holds a word read from the array.
- fetch_misalign  out  1  fetch_addr[1:0] was nonzero for the word in fetch_data.
- prog_lock  in  1  bootloader requests exclusive access.
- prog_we  in  1  write strobe.
- prog_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- prog_data  in  32  write data, little-endian byte lanes.
- prog_be  in  4  byte enables; bit i enables prog_data[8i+7:8i].
- prog_busy  out  1  high in PROG and DRAIN.
- prog_count  out  16  writes accepted since the last entry to PROG; saturates at 16'hFFFF.
- parity_err  out  1  parity mismatch on the word in fetch_data. Constant 0 without the macro.

## Operation
- The FSM has three states: RUN, PROG and DRAIN. Reset state is RUN.
- RUN -> PROG when prog_lock=1. The transition happens whatever the values of stall and fetch_req.
- PROG -> DRAIN when prog_lock=0.
- DRAIN -> RUN after exactly one cycle. If prog_lock=1 in DRAIN, go to PROG instead.
- RUN fetch behaviour:
  - fetch_req=1 and stall=0: read word index; on the next edge fetch_valid=1 and fetch_data=array word. fetch_misalign is set from the captured addr[1:0] != 0.
  - stall=1: fetch_data, fetch_valid, fetch_misalign and parity_err all hold. No read is issued and fetch_addr/fetch_req are ignored.
  - fetch_req=0 and stall=0: fetch_valid goes to 0 on the next edge. fetch_data holds its value.
- PROG and DRAIN:
  - fetch_valid=0, fetch_data=NOP_WORD, fetch_misalign=0, parity_err=0.
  - Fetch requests are dropped, including under stall.
- Writes:
  - Accepted only in PROG when prog_we=1. Each enabled byte lane is written on that edge.
  - prog_be=4'b0000 writes nothing but still increments prog_count.
  - prog_we in RUN or DRAIN is ignored and does not count.
- prog_count:
  - Cleared on every RUN/DRAIN -> PROG transition.
  - Holds its value in RUN so the bootloader can read it back.
- Address wrap: all index arithmetic is modulo depth; no out-of-range case exists.
- Array contents are not reset. Only registers are reset.

## Timing
- Reset values: fetch_data=NOP_WORD, fetch_valid=0, fetch_misalign=0, parity_err=0, prog_busy=0, prog_count=0, state=RUN.
- Reset asserted mid-write aborts that write: no array update on an edge where rst=1.
- Fetch latency: 1 cycle, request at edge N produces data after edge N+1. Throughput is one word per cycle.
- prog_busy is registered: it rises on the edge entering PROG and falls on the edge leaving DRAIN.
- The first RUN fetch after DRAIN reads post-write contents. There is no forwarding path and none is needed, because writes and reads never coexist.
- Write-to-readback: a word written in PROG is visible to the first fetch after DRAIN, i.e. a minimum of 3 cycles after the write edge.

## Configuration
- IMEM_PARITY_EN defined:
  - The array stores 4 extra bits, each the even parity of one byte lane, updated only for enabled lanes on write.
  - On every RUN read the parity is recomputed. parity_err is registered with fetch_data and holds under stall.
  - fetch_data is passed through unmodified.
- IMEM_PARITY_EN undefined: no parity storage and parity_err is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then fetch_req=1 at addr 0x0000 after preloading 0x00500093 -> one cycle later fetch_valid=1 and fetch_data=0x00500093. Before the first fetch, fetch_data=0x00000013.
- Back-to-back fetches of 0x0, 0x4, 0x8 with stall=1 on the second cycle -> the 0x4 word stays on fetch_data for the stalled cycle. The sequence continues 0x4 then 0x8 with no duplicate and no skip.
- prog_lock=1, writes of 0xDEADBEEF to 0x10 with be=4'hF and 0x000000AA to 0x10 with be=4'h1, then unlock:
  - prog_count=2.
  - prog_busy drops one cycle after lock release.
  - Fetching 0x10 returns 0xDEADBEAA.
- prog_we=1 in RUN to 0x20 -> array unchanged and prog_count unchanged. Fetch at 0x22 returns the old word with fetch_misalign=1.
- rst pulsed in PROG during a write -> the write is dropped, state=RUN, prog_count=0 and fetch_data=NOP_WORD.
- With IMEM_PARITY_EN, force-flip one stored data bit at 0x30 and fetch it -> parity_err=1 in the same cycle as fetch_valid. A clean word gives parity_err=0.
